// File: rtl/mem_load_arbiter.sv
// Data-memory write-port owner: buffers host loader beats in a FIFO,
// commits them while the CPU is held, then hands the port to the CPU.
module mem_load_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [2:0]        ext_store,
    input  logic              ext_last,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_store,
    input  logic              mem_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_store,
    output logic              cpu_run,
    output logic              busy,
    output logic [CNT_W-1:0]  load_count,
    output logic              err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN
    } state_t;

    state_t state;
    state_t nextState;

    logic [ADDR_W-1:0] fifoAddr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData  [FIFO_DEPTH];
    logic [2:0]        fifoStore [FIFO_DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   fill;

    logic full;
    logic empty;
    logic loading;
    logic beatOk;
    logic accept;
    logic push;
    logic pop;

    logic              commitWe;
    logic [ADDR_W-1:0] commitAddr;
    logic [DATA_W-1:0] commitData;
    logic [2:0]        commitStore;

    logic [CNT_W-1:0] count;
    logic             errQ;
    logic             runQ;

    assign empty   = (fill == '0);
    assign full    = (fill == FULL_FILL);
    assign loading = (state == LOAD) || (state == DRAIN);

    assign ext_ready = (state == LOAD) && !full;
    assign accept    = ext_valid && ext_ready;
    assign push      = accept && beatOk;
    assign pop       = loading && !empty && !mem_stall;

    // Misaligned halfword/word stores and unknown store types are refused.
    always_comb begin
        beatOk = 1'b0;
        case (ext_store)
            3'b000:  beatOk = 1'b1;
            3'b001:  beatOk = !ext_addr[0];
            3'b010:  beatOk = (ext_addr[1:0] == 2'b00);
            default: beatOk = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    nextState = LOAD;
                end else if (run_start) begin
                    nextState = RUN;
                end
            end
            LOAD: begin
                if (accept && ext_last) begin
                    nextState = DRAIN;
                end
            end
            // Wait for the last registered write to leave before handing over.
            DRAIN: begin
                if (empty && !commitWe) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    nextState = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr]  <= ext_addr;
            fifoData[wrPtr]  <= ext_wdata;
            fifoStore[wrPtr] <= ext_store;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            fill        <= '0;
            commitWe    <= 1'b0;
            commitAddr  <= '0;
            commitData  <= '0;
            commitStore <= '0;
            count       <= '0;
            errQ        <= 1'b0;
            runQ        <= 1'b0;
        end else begin
            state <= nextState;
            runQ  <= (nextState == RUN);

            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase

            commitWe    <= pop;
            commitAddr  <= pop ? fifoAddr[rdPtr]  : '0;
            commitData  <= pop ? fifoData[rdPtr]  : '0;
            commitStore <= pop ? fifoStore[rdPtr] : '0;

            if ((nextState == LOAD) && (state != LOAD)) begin
                count <= '0;
                errQ  <= 1'b0;
            end else begin
                if (pop && (count != '1)) begin
                    count <= count + 1'b1;
                end
                if (accept && !beatOk) begin
                    errQ <= 1'b1;
                end
            end
        end
    end

    // In RUN the CPU owns the port with no added latency.
    assign mem_we    = (state == RUN) ? cpu_memwrite : commitWe;
    assign mem_addr  = (state == RUN) ? cpu_addr     : commitAddr;
    assign mem_wdata = (state == RUN) ? cpu_wdata    : commitData;
    assign mem_store = (state == RUN) ? cpu_store    : commitStore;

    assign cpu_run    = runQ;
    assign busy       = loading;
    assign load_count = count;
    assign err        = errQ;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Bench for mem_load_arbiter: directed sessions, a validation table,
// and a randomized run against a queue-based reference model.
module tb_mem_load_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
    } beat_t;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] a;
        int          wr;
        bit          e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_start, run_start;
    logic          ext_valid, ext_ready;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [2:0]    ext_store;
    logic          ext_last;
    logic          cpu_memwrite;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [2:0]    cpu_store;
    logic          mem_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_store;
    logic          cpu_run, busy, err;
    logic [CW-1:0] load_count;

    mem_load_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .run_start(run_start),
        .ext_valid(ext_valid), .ext_ready(ext_ready),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_store(ext_store), .ext_last(ext_last),
        .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_store(cpu_store),
        .mem_stall(mem_stall),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_store(mem_store),
        .cpu_run(cpu_run), .busy(busy),
        .load_count(load_count), .err(err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    beat_t seen[$];

    // Memory writes issued on behalf of the loader.
    always @(negedge clk) begin
        if (mem_we && !cpu_run) begin
            seen.push_back({mem_addr, mem_wdata, mem_store});
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clearIn();
        load_start = 0; run_start = 0;
        ext_valid = 0; ext_addr = '0; ext_wdata = '0;
        ext_store = '0; ext_last = 0;
        cpu_memwrite = 0; cpu_addr = '0; cpu_wdata = '0;
        cpu_store = '0; mem_stall = 0;
    endtask

    task automatic pulseLoad();
        load_start = 1;
        tick();
        load_start = 0;
    endtask

    task automatic sendBeat(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s, input logic last);
        bit ok = 0;
        logic r;
        ext_valid = 1; ext_addr = a; ext_wdata = d;
        ext_store = s; ext_last = last;
        for (int n = 0; n < 40; n++) begin
            settle();
            r = ext_ready;
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        ext_valid = 0; ext_last = 0;
        chk("beat_accepted", ok, 1);
    endtask

    task automatic waitRun();
        bit found = 0;
        for (int n = 0; n < 60; n++) begin
            settle();
            if (cpu_run) begin
                found = 1;
                tick();
                break;
            end
            tick();
        end
        chk("run_reached", found, 1);
    endtask

    // Reference model state.
    int          mMode;
    beat_t       mq[$];
    logic        mWe;
    beat_t       mOut;
    logic [CW-1:0] mCnt;
    logic        mErr;
    logic        mRun;

    function automatic bit legal(beat_t b);
        case (b.s)
            3'd0:    return 1;
            3'd1:    return b.a[0] == 1'b0;
            3'd2:    return b.a[1:0] == 2'b00;
            default: return 0;
        endcase
    endfunction

    task automatic modelStep(logic rdy);
        bit popNow = (mMode == 1 || mMode == 2) && mq.size() > 0 && !mem_stall;
        bit acc = ext_valid && rdy;
        int nm = mMode;
        case (mMode)
            0: if (load_start) nm = 1; else if (run_start) nm = 3;
            1: if (acc && ext_last) nm = 2;
            2: if (mq.size() == 0 && !mWe) nm = 3;
            default: if (load_start) nm = 1;
        endcase
        if (popNow) begin
            mWe = 1;
            mOut = mq.pop_front();
            if (mCnt != '1) mCnt++;
        end else begin
            mWe = 0;
            mOut = '0;
        end
        if (acc) begin
            if (legal({ext_addr, ext_wdata, ext_store})) mq.push_back({ext_addr, ext_wdata, ext_store});
            else mErr = 1;
        end
        if (nm == 1 && mMode != 1) begin
            mCnt = '0;
            mErr = 0;
        end
        mRun = (nm == 3);
        mMode = nm;
    endtask

    vec_t vt[12];

    initial begin
        clearIn();
        vt[0]  = '{3'd0, 32'h1,  1, 0};
        vt[1]  = '{3'd0, 32'h3,  1, 0};
        vt[2]  = '{3'd1, 32'h0,  1, 0};
        vt[3]  = '{3'd1, 32'h2,  1, 0};
        vt[4]  = '{3'd1, 32'h1,  0, 1};
        vt[5]  = '{3'd2, 32'h0,  1, 0};
        vt[6]  = '{3'd2, 32'h4,  1, 0};
        vt[7]  = '{3'd2, 32'h2,  0, 1};
        vt[8]  = '{3'd2, 32'h1,  0, 1};
        vt[9]  = '{3'd3, 32'h0,  0, 1};
        vt[10] = '{3'd7, 32'h0,  0, 1};
        vt[11] = '{3'd4, 32'h8,  0, 1};

        // Reset state
        repeat (3) tick();
        settle();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ready", ext_ready, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", load_count, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        tick();
        reset = 1;
        tick();

        // Three word beats, back to back
        pulseLoad();
        ext_valid = 1; ext_addr = 32'h0; ext_wdata = 32'hA5A5_0001; ext_store = 3'd2;
        settle();
        chk("t1_ready", ext_ready, 1);
        chk("t1_busy", busy, 1);
        tick();
        ext_addr = 32'h4; ext_wdata = 32'hA5A5_0002;
        settle();
        chk("t1_lat_we0", mem_we, 0);
        tick();
        ext_addr = 32'h8; ext_wdata = 32'hA5A5_0003; ext_last = 1;
        settle();
        chk("t1_w0", {mem_we, mem_addr, mem_wdata, mem_store}, {1'b1, 32'h0, 32'hA5A5_0001, 3'd2});
        tick();
        ext_valid = 0; ext_last = 0;
        settle();
        chk("t1_w1", {mem_we, mem_addr, mem_wdata, mem_store}, {1'b1, 32'h4, 32'hA5A5_0002, 3'd2});
        tick();
        settle();
        chk("t1_w2", {mem_we, mem_addr, mem_wdata, mem_store}, {1'b1, 32'h8, 32'hA5A5_0003, 3'd2});
        chk("t1_count", load_count, 3);
        tick();
        settle();
        chk("t1_idle_we", mem_we, 0);
        chk("t1_run_early", cpu_run, 0);
        tick();
        settle();
        chk("t1_run", cpu_run, 1);
        chk("t1_busy_off", busy, 0);
        tick();

        // CPU passthrough, then reload stops it
        cpu_memwrite = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1234;
        cpu_store = 3'd1; mem_stall = 1;
        settle();
        chk("t4_pass", {mem_we, mem_addr, mem_wdata, mem_store}, {1'b1, 32'h40, 32'h1234, 3'd1});
        chk("t4_ready", ext_ready, 0);
        tick();
        cpu_memwrite = 0; mem_stall = 0; load_start = 1;
        settle();
        chk("t4_run_hold", cpu_run, 1);
        tick();
        load_start = 0;
        settle();
        chk("t4_stopped", cpu_run, 0);
        chk("t4_ready_load", ext_ready, 1);
        chk("t4_count_clr", load_count, 0);
        tick();

        // Stall: fill the FIFO, then drain in order
        seen.delete();
        mem_stall = 1;
        for (int i = 0; i < 4; i++) sendBeat(32'h100 + 4 * i, 32'hB000 + i, 3'd2, 0);
        ext_valid = 1; ext_addr = 32'h110; ext_wdata = 32'hB004; ext_store = 3'd2;
        settle();
        chk("t2_full_ready", ext_ready, 0);
        tick();
        settle();
        chk("t2_full_ready2", ext_ready, 0);
        chk("t2_no_write", seen.size(), 0);
        tick();
        mem_stall = 0;
        sendBeat(32'h110, 32'hB004, 3'd2, 0);
        sendBeat(32'h114, 32'hB005, 3'd2, 1);
        waitRun();
        chk("t2_n", seen.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < seen.size()) begin
                chk($sformatf("t2_beat%0d", i), {seen[i].a, seen[i].d},
                    {32'h100 + 32'(4 * i), 32'hB000 + 32'(i)});
            end
        end
        settle();
        chk("t2_count", load_count, 6);
        tick();

        // Rejected beats
        seen.delete();
        pulseLoad();
        sendBeat(32'h6, 32'hAA, 3'd2, 0);
        sendBeat(32'h3, 32'hBB, 3'd1, 0);
        sendBeat(32'h3, 32'hCC, 3'd0, 1);
        waitRun();
        settle();
        chk("t3_err", err, 1);
        chk("t3_count", load_count, 1);
        chk("t3_n", seen.size(), 1);
        if (seen.size() > 0) chk("t3_sb", seen[0], {32'h3, 32'hCC, 3'd0});
        tick();

        // Validation table, one single-beat session each
        foreach (vt[i]) begin
            seen.delete();
            pulseLoad();
            sendBeat(vt[i].a, 32'hD000 + 32'(i), vt[i].st, 1);
            waitRun();
            settle();
            chk($sformatf("vec%0d_wr", i), seen.size(), vt[i].wr);
            chk($sformatf("vec%0d_err", i), err, vt[i].e);
            chk($sformatf("vec%0d_cnt", i), load_count, vt[i].wr);
            tick();
        end

        // Saturating load_count
        pulseLoad();
        for (int i = 0; i < 9; i++) sendBeat(32'h300 + i, 32'(i), 3'd0, i == 8);
        waitRun();
        settle();
        chk("sat_count", load_count, 7);
        tick();

        // Reset mid-load with beats queued
        pulseLoad();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) sendBeat(32'h200 + 4 * i, 32'hE000 + i, 3'd2, 0);
        mem_stall = 0;
        tick();
        mem_stall = 1;
        settle();
        chk("t5_pre_we", mem_we, 1);
        reset = 0;
        #1;
        chk("t5_we_async", mem_we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", ext_ready, 0);
        chk("t5_count", load_count, 0);
        seen.delete();
        tick();
        tick();
        reset = 1;
        mem_stall = 0;
        repeat (6) tick();
        settle();
        chk("t5_no_write", seen.size(), 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_run", cpu_run, 0);
        chk("t5_idle_ready", ext_ready, 0);
        tick();

        // run_start without a load
        run_start = 1;
        tick();
        run_start = 0;
        settle();
        chk("t6_run", cpu_run, 1);
        chk("t6_count", load_count, 0);
        chk("t6_err", err, 0);
        tick();

        // Randomized run against the reference model
        reset = 0;
        tick();
        tick();
        reset = 1;
        mMode = 0; mq.delete(); mWe = 0; mOut = '0;
        mCnt = '0; mErr = 0; mRun = 0;
        begin
            bit    hv = 0;
            bit    hl = 0;
            beat_t hb = '0;
            logic  eRdy;
            beat_t eOut;
            logic  eWe;
            for (int c = 0; c < 3000; c++) begin
                load_start = ($urandom % 24 == 0);
                run_start = ($urandom % 16 == 0);
                mem_stall = ($urandom % 3 == 0);
                cpu_memwrite = $urandom % 2;
                cpu_addr = $urandom;
                cpu_wdata = $urandom;
                cpu_store = 3'($urandom % 8);
                if (!hv && ($urandom % 2 == 1)) begin
                    hv = 1;
                    hb.a = $urandom;
                    if ($urandom % 4 != 0) hb.a[1:0] = 2'b00;
                    hb.d = $urandom;
                    hb.s = ($urandom % 8 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
                    hl = ($urandom % 8 == 0);
                end
                ext_valid = hv;
                ext_addr = hb.a;
                ext_wdata = hb.d;
                ext_store = hb.s;
                ext_last = hl;
                settle();
                eRdy = (mMode == 1) && (mq.size() < DEPTH);
                if (mMode == 3) begin
                    eWe = cpu_memwrite;
                    eOut = {cpu_addr, cpu_wdata, cpu_store};
                end else begin
                    eWe = mWe;
                    eOut = mOut;
                end
                chk($sformatf("rand_c%0d", c),
                    {ext_ready, mem_we, mem_addr, mem_wdata, mem_store, cpu_run, busy, load_count, err},
                    {eRdy, eWe, eOut, mRun, (mMode == 1 || mMode == 2), mCnt, mErr});
                modelStep(eRdy);
                if (hv && eRdy) hv = 0;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
